// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths and the MEM/WB bundle layout.
package pipe_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_AW   = 5;
  // Byte-address bits below the 32-bit word index.
  localparam int unsigned WORD_OFS = 2;

  localparam int unsigned WB_REGWR_W = 1;
  localparam int unsigned WB_RW_W    = REG_AW;
  localparam int unsigned WB_DATA_W  = DATA_W;

  typedef struct packed {
    logic [WB_REGWR_W-1:0] reg_wr;
    logic [WB_RW_W-1:0]    rw;
    logic [WB_DATA_W-1:0]  data;
  } mem_wb_t;

endpackage

// File: rtl/data_mem.sv
// Word-addressed data memory: synchronous write, asynchronous read, no reset.
module data_mem #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];

  // Store on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Combinational read of the addressed word (pre-write value on a same-cycle store).
  always_comb begin
    rdata = mem_q[addr];
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: alignment check, data-memory access, MEM/WB register, forwarding taps.
module mem_wb_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DMEM_AW = 10,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              MEM_MemtoReg,
  input  logic              MEM_MemWr,
  input  logic              MEM_RegWr,
  input  logic [4:0]        MEM_Rw,
  input  logic [DATA_W-1:0] MEM_Result,
  input  logic [DATA_W-1:0] MEM_BusB,
  output logic              WB_RegWr,
  output logic [4:0]        WB_Rw,
  output logic [DATA_W-1:0] WB_Data,
  output logic              FWD_MEM_RegWr,
  output logic [4:0]        FWD_MEM_Rw,
  output logic [DATA_W-1:0] FWD_MEM_Data,
  output logic              Align_Err
);

  logic               misaligned;
  logic               mem_we;
  logic [DMEM_AW-1:0] word_idx;
  logic [DATA_W-1:0]  rdata;
  mem_wb_t            wb_d, wb_q;
  logic               align_d, align_q;

  // Address decode, alignment check and write enable (held off while in reset).
  always_comb begin
    word_idx   = MEM_Result[DMEM_AW+WORD_OFS-1:WORD_OFS];
    misaligned = (MEM_MemWr | MEM_MemtoReg) & (MEM_Result[WORD_OFS-1:0] != '0);
    mem_we     = MEM_MemWr & ~misaligned & reset;
  end

  data_mem #(
    .AW (DMEM_AW),
    .DW (DATA_W)
  ) u_dmem (
    .clk   (CLK),
    .we    (mem_we),
    .addr  (word_idx),
    .wdata (MEM_BusB),
    .rdata (rdata)
  );

  // Next MEM/WB contents and sticky alignment flag.
  always_comb begin
    wb_d        = '0;
    wb_d.reg_wr = MEM_RegWr & ~misaligned;
    wb_d.rw     = MEM_Rw;
    wb_d.data   = MEM_MemtoReg ? rdata : MEM_Result;
    align_d     = align_q | misaligned;
  end

  // MEM/WB register and error flag, cleared asynchronously.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wb_q    <= '0;
      align_q <= 1'b0;
    end else begin
      wb_q    <= wb_d;
      align_q <= align_d;
    end
  end

  // Output drive: registered write-back and combinational forwarding taps.
  always_comb begin
    WB_RegWr      = wb_q.reg_wr;
    WB_Rw         = wb_q.rw;
    WB_Data       = wb_q.data;
    Align_Err     = align_q;
    FWD_MEM_RegWr = MEM_RegWr & ~misaligned;
    FWD_MEM_Rw    = MEM_Rw;
    FWD_MEM_Data  = MEM_Result;
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage.
module tb_mem_wb_stage;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        MEM_MemtoReg = 1'b0, MEM_MemWr = 1'b0, MEM_RegWr = 1'b0;
  logic [4:0]  MEM_Rw = '0;
  logic [31:0] MEM_Result = '0, MEM_BusB = '0;
  logic        WB_RegWr, FWD_MEM_RegWr, Align_Err;
  logic [4:0]  WB_Rw, FWD_MEM_Rw;
  logic [31:0] WB_Data, FWD_MEM_Data;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  logic [37:0] sb [$];          // {reg_wr, rw, data}
  logic [31:0] mdl [int];       // reference memory, keyed by word index
  logic        align_mdl = 1'b0;

  mem_wb_stage #(.DMEM_AW(10), .DATA_W(32)) dut (
    .CLK(CLK), .reset(reset),
    .MEM_MemtoReg(MEM_MemtoReg), .MEM_MemWr(MEM_MemWr), .MEM_RegWr(MEM_RegWr),
    .MEM_Rw(MEM_Rw), .MEM_Result(MEM_Result), .MEM_BusB(MEM_BusB),
    .WB_RegWr(WB_RegWr), .WB_Rw(WB_Rw), .WB_Data(WB_Data),
    .FWD_MEM_RegWr(FWD_MEM_RegWr), .FWD_MEM_Rw(FWD_MEM_Rw), .FWD_MEM_Data(FWD_MEM_Data),
    .Align_Err(Align_Err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic m2r, input logic wr, input logic rg,
                       input logic [4:0] rw, input logic [31:0] res, input logic [31:0] busb);
    MEM_MemtoReg = m2r; MEM_MemWr = wr; MEM_RegWr = rg;
    MEM_Rw = rw; MEM_Result = res; MEM_BusB = busb;
  endtask

  // Model the current MEM-stage inputs, push the expected MEM/WB word, clock once.
  task automatic step();
    logic        mis;
    int          idx;
    logic [31:0] rd;
    mis = (MEM_MemWr | MEM_MemtoReg) & (MEM_Result[1:0] != 2'b00);
    idx = int'(MEM_Result[11:2]);
    rd  = mdl.exists(idx) ? mdl[idx] : 32'hxxxx_xxxx;
    sb.push_back({MEM_RegWr & ~mis, MEM_Rw, MEM_MemtoReg ? rd : MEM_Result});
    if (MEM_MemWr && !mis) mdl[idx] = MEM_BusB;
    align_mdl = align_mdl | mis;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom);
      @(posedge CLK); #1;
      n_total++;
      if ({WB_RegWr, WB_Rw, WB_Data, Align_Err} !== 39'd0)
        $display("FAIL reset_hold: got regwr=%b rw=%0d data=%h aerr=%b want all 0",
                 WB_RegWr, WB_Rw, WB_Data, Align_Err);
      else n_pass++;
    end
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 5'd3, 32'h0BAD_F00D, 32'h0);
    step();
    begin
      logic [37:0] e;
      e = sb.pop_front();
      n_total++;
      if ({WB_RegWr, WB_Rw, WB_Data} !== e)
        $display("FAIL reset_release: got %h want %h", {WB_RegWr, WB_Rw, WB_Data}, e);
      else n_pass++;
    end
  endtask

  task automatic test_alu();
    logic [37:0] e;
    drive(1'b0, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 32'h0);
    #1;
    n_total++;
    if ({FWD_MEM_RegWr, FWD_MEM_Rw, FWD_MEM_Data} !== {1'b1, 5'd5, 32'h1234_5678})
      $display("FAIL alu_fwd: got %b %0d %h want 1 5 12345678", FWD_MEM_RegWr, FWD_MEM_Rw, FWD_MEM_Data);
    else n_pass++;
    step();
    e = sb.pop_front();
    n_total++;
    if ({WB_RegWr, WB_Rw, WB_Data} !== e)
      $display("FAIL alu_wb: got %h want %h", {WB_RegWr, WB_Rw, WB_Data}, e);
    else n_pass++;
  endtask

  task automatic test_store_load();
    logic [37:0] e;
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h40, 32'hDEAD_BEEF); step(); void'(sb.pop_front());
    drive(1'b1, 1'b0, 1'b1, 5'd9, 32'h40, 32'h0); step();
    e = sb.pop_front();
    n_total++;
    if ({WB_RegWr, WB_Rw, WB_Data} !== e || e !== {1'b1, 5'd9, 32'hDEAD_BEEF})
      $display("FAIL store_load: got %h want %h", {WB_RegWr, WB_Rw, WB_Data}, e);
    else n_pass++;
  endtask

  task automatic test_alias();
    logic [37:0] e;
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h1004, 32'hA5A5_A5A5); step(); void'(sb.pop_front());
    drive(1'b1, 1'b0, 1'b1, 5'd2, 32'h0004, 32'h0); step();
    e = sb.pop_front();
    n_total++;
    if ({WB_RegWr, WB_Rw, WB_Data} !== e)
      $display("FAIL alias: got %h want %h", {WB_RegWr, WB_Rw, WB_Data}, e);
    else n_pass++;
  endtask

  task automatic test_misaligned();
    logic [37:0] e;
    drive(1'b1, 1'b0, 1'b1, 5'd7, 32'h42, 32'h0);
    #1;
    n_total++;
    if (FWD_MEM_RegWr !== 1'b0)
      $display("FAIL mis_fwd_squash: got %b want 0", FWD_MEM_RegWr);
    else n_pass++;
    step();
    e = sb.pop_front();
    n_total++;
    if ({WB_RegWr, WB_Rw, WB_Data[31:0] & 32'h0} !== {e[37:32], 32'h0})
      $display("FAIL mis_load: got regwr=%b rw=%0d want regwr=%b rw=%0d", WB_RegWr, WB_Rw, e[37], e[36:32]);
    else n_pass++;
    n_total++;
    if (Align_Err !== align_mdl || align_mdl !== 1'b1)
      $display("FAIL mis_flag_set: got %b want 1", Align_Err);
    else n_pass++;
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h40, 32'h1); step(); void'(sb.pop_front());
    drive(1'b1, 1'b0, 1'b1, 5'd4, 32'h40, 32'h0); step();
    e = sb.pop_front();
    n_total++;
    if ({WB_RegWr, WB_Rw, WB_Data} !== e || Align_Err !== 1'b1)
      $display("FAIL mis_recover: got %h aerr=%b want %h aerr=1", {WB_RegWr, WB_Rw, WB_Data}, Align_Err, e);
    else n_pass++;
    drive(1'b0, 1'b1, 1'b1, 5'd6, 32'h41, 32'hFFFF_FFFF); step(); void'(sb.pop_front());
    drive(1'b1, 1'b0, 1'b1, 5'd8, 32'h40, 32'h0); step();
    e = sb.pop_front();
    n_total++;
    if ({WB_RegWr, WB_Rw, WB_Data} !== e || e[31:0] !== 32'h1)
      $display("FAIL mis_store_blocked: got %h want %h", {WB_RegWr, WB_Rw, WB_Data}, e);
    else n_pass++;
  endtask

  task automatic test_reset_mid_store();
    logic [37:0] e;
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h80, 32'h1111_2222); step(); void'(sb.pop_front());
    drive(1'b0, 1'b0, 1'b1, 5'd17, 32'hCAFE_0001, 32'h0); step(); void'(sb.pop_front());
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h80, 32'h5555_0000);
    #2 reset = 1'b0;
    #1;
    n_total++;
    if ({WB_RegWr, WB_Rw, WB_Data, Align_Err} !== 39'd0)
      $display("FAIL reset_async: got regwr=%b rw=%0d data=%h aerr=%b want all 0",
               WB_RegWr, WB_Rw, WB_Data, Align_Err);
    else n_pass++;
    align_mdl = 1'b0;
    @(posedge CLK); #1;
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 5'd10, 32'h80, 32'h0); step();
    e = sb.pop_front();
    n_total++;
    if ({WB_RegWr, WB_Rw, WB_Data} !== e || e[31:0] !== 32'h1111_2222)
      $display("FAIL reset_store_lost: got %h want %h", {WB_RegWr, WB_Rw, WB_Data}, e);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [37:0] e;
    for (int a = 0; a < 8; a++) begin
      drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h100 + 32'(a * 4), $urandom); step(); void'(sb.pop_front());
    end
    for (int i = 0; i < 48; i++) begin
      logic [31:0] addr;
      addr = 32'h100 + 32'($urandom_range(0, 7) * 4) + (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
      case ($urandom_range(0, 3))
        0: drive(1'b0, 1'b0, 1'($urandom), 5'($urandom), $urandom, 32'h0);
        1: drive(1'b0, 1'b1, 1'($urandom), 5'($urandom), addr, $urandom);
        2: drive(1'b1, 1'b0, 1'b1, 5'($urandom), addr, 32'h0);
        default: drive(1'b1, 1'b1, 1'b1, 5'($urandom), addr, $urandom);
      endcase
      step();
      e = sb.pop_front();
      n_total++;
      if ({WB_RegWr, WB_Rw, WB_Data} !== e || Align_Err !== align_mdl)
        $display("FAIL b2b_%0d: got %h aerr=%b want %h aerr=%b",
                 i, {WB_RegWr, WB_Rw, WB_Data}, Align_Err, e, align_mdl);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store_load();
    test_alias();
    test_misaligned();
    test_reset_mid_store();
    test_back_to_back();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage of the 5-stage pipeline. It consumes the EXE/MEM pipeline register outputs (MEM_* control, MEM_Result address/ALU value, MEM_BusB store data).
- It performs the data-memory load/store and registers the write-back result into the MEM/WB register that drives the register-file write port.
- It also exposes MEM-stage forwarding taps for the hazard/forward unit.

Parameters:
- DMEM_AW, 10, log2 of data-memory depth in 32-bit words (1024 words = 4 KiB).
- DATA_W, 32, datapath width; fixed at 32, present for package consistency.

Ports:
- CLK  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- MEM_MemtoReg  in  1  1 = load; write-back takes memory data
- MEM_MemWr  in  1  1 = store MEM_BusB to memory
- MEM_RegWr  in  1  instruction writes the register file
- MEM_Rw  in  5  destination register number
- MEM_Result  in  32  ALU result; byte address for load/store
- MEM_BusB  in  32  store data
- WB_RegWr  out  1  registered register-file write enable
- WB_Rw  out  5  registered destination register
- WB_Data  out  32  registered write-back data
- FWD_MEM_RegWr  out  1  combinational: MEM-stage instruction will write a register (after alignment squash)
- FWD_MEM_Rw  out  5  combinational: equals MEM_Rw
- FWD_MEM_Data  out  32  combinational: equals MEM_Result (ALU forwarding only; loads are not forwardable from MEM)
- Align_Err  out  1  sticky misaligned-access flag

Behaviour:
- Reset (reset=0, asynchronous):
  - WB_RegWr=0, WB_Rw=0, WB_Data=0, Align_Err=0.
  - While reset is low, memory writes are blocked.
  - Memory contents are not cleared; words never written read X.
- Word index = MEM_Result[DMEM_AW+1:2]. Upper address bits are ignored, so addresses alias modulo 4 KiB.
- Misaligned = (MEM_MemWr | MEM_MemtoReg) & (MEM_Result[1:0] != 0).
  - Misaligned access: the store is suppressed.
  - Misaligned access: the register write is squashed (captured WB_RegWr=0, FWD_MEM_RegWr=0).
  - Misaligned access: Align_Err is set on that edge and stays set until reset.
- Store: on a rising edge with reset=1, MEM_MemWr=1 and aligned, mem[index] <= MEM_BusB.
- Load: asynchronous read of mem[index] in the same cycle. This gives 1-cycle latency from the MEM stage to WB_Data.
- MEM/WB register (every rising edge, reset=1):
  - WB_RegWr <= MEM_RegWr & ~misaligned
  - WB_Rw <= MEM_Rw
  - WB_Data <= MEM_MemtoReg ? rdata : MEM_Result
- No stall or flush inputs; the stage advances every cycle. Bubbles arrive as all-zero control.
- Store at cycle N followed by a load of the same address at N+1: the load returns the new data.
- A load and a store cannot be in MEM together. If MEM_MemWr and MEM_MemtoReg are both 1 and aligned:
  - the store is performed, and
  - WB_Data gets the pre-write (old) word.
- If reset is asserted in the same cycle as a store, the store is lost and the MEM/WB register clears immediately.
- After reset is released, the first rising edge captures normally.

Decomposition:
- Shared package pipe_pkg holds:
  - DATA_W = 32 and REG_AW = 5
  - the word-offset slice constant (2)
  - the MEM/WB bundle field widths
- One sub-module, data_mem: 2^DMEM_AW x 32 array, synchronous write with write enable, asynchronous read, no reset.
- The stage top holds the alignment check, write-back mux, MEM/WB register, sticky flag and forwarding taps.

Test Plan:
- Reset check: hold reset=0 with random inputs toggling and clocks running -> WB_RegWr=0, WB_Rw=0, WB_Data=0, Align_Err=0 throughout; release reset -> the next edge captures the inputs.
- ALU pass-through: MemtoReg=0, RegWr=1, Rw=5, Result=0x1234_5678 -> one edge later WB_RegWr=1, WB_Rw=5, WB_Data=0x1234_5678; FWD_MEM_Data equals 0x1234_5678 in the same cycle.
- Store then load: store BusB=0xDEAD_BEEF at address 0x40, next cycle load address 0x40, Rw=9 -> WB_Data=0xDEAD_BEEF, WB_Rw=9, WB_RegWr=1.
- Aliasing: store 0xA5A5_A5A5 to 0x1004, then load 0x0004 -> 0xA5A5_A5A5.
- Misaligned: load address 0x42 with RegWr=1 -> WB_RegWr=0 and Align_Err=1 after the edge; a following aligned store to 0x40 of 0x1 followed by a load returns 0x1 while Align_Err stays 1; misaligned store to 0x41 leaves mem[0x40] unchanged.
- Reset mid-store: assert reset low between edges with MemWr=1 at 0x80 and data 0x5555_0000 -> outputs clear asynchronously; after release, a load of 0x80 returns the previous value, not 0x5555_0000.
